uart_serial_sink: RTL and testbench

Serial-line receiver that consumes the `TX` output of `uart_top` and turns it back into characters plus per-character status. It sits directly downstream of the UART in the block_uart environment, alongside the Wishbone driver. It provides an RTL checker and loopback source that needs no software model: 16x oversampled start-bit detection, mid-bit sampling, 5–8 data bits, optional parity, 1 or 2 stop bits, and break detection. Results go into a small FIFO drained through a valid/ready port.

---
 rtl/uart_sink_pkg.sv | 37 +++
 rtl/uart_sink_fifo.sv | 58 +++++
 rtl/uart_serial_sink.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_serial_sink.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sink_pkg.sv
// Shared types and constants for the serial-line receiver that checks uart_top TX output.
package uart_sink_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } state_t;

  localparam int STAT_BRK = 3;
  localparam int STAT_FE  = 2;
  localparam int STAT_PE  = 1;
  localparam int STAT_OE  = 0;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  // Index of the final data bit (LSB-first) for a given char_len encoding.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
    logic [2:0] idx;
    case (len)
      LEN_5:   idx = 3'd4;
      LEN_6:   idx = 3'd5;
      LEN_7:   idx = 3'd6;
      LEN_8:   idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_sink_fifo.sv
// Synchronous character FIFO; the head entry is visible while the FIFO is non-empty.
module uart_sink_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/uart_serial_sink.sv
// 16x oversampling serial receiver: start detection, mid-bit sampling, parity/stop/break checks.
module uart_serial_sink
  import uart_sink_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               wb_clock,
  input  logic                               wb_rst_n,
  input  logic [DIV_WIDTH-1:0]               divisor,
  input  logic [1:0]                         char_len,
  input  logic                               parity_en,
  input  logic                               parity_even,
  input  logic                               stop2,
  input  logic                               rx,
  output logic [7:0]                         rx_data,
  output logic [3:0]                         rx_status,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 rx_meta;
  logic                 rxs;
  logic [DIV_WIDTH-1:0] tick_cnt;
  logic [DIV_WIDTH-1:0] div_load;
  logic                 tick;

  state_t     state, state_next;
  logic [3:0] sc, sc_next;
  logic [2:0] bit_idx, bit_next;
  logic [7:0] data_sr, data_next;
  logic       par_bit, par_next;
  logic       pe_flag, pe_next;
  logic       ovr_pending;

  logic       push_req;
  logic       brk;
  logic       fe;
  logic [7:0] push_data;
  logic [3:0] push_status;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic [11:0] fifo_head;

  // Synchronizer idles high so a reset never looks like a start bit by itself.
  always_ff @(posedge wb_clock or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign div_load = (divisor == '0) ? '0 : divisor - DIV_WIDTH'(1);
  assign tick     = (tick_cnt == '0);

  always_ff @(posedge wb_clock or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= div_load;
    end else begin
      tick_cnt <= tick_cnt - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge wb_clock or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state   <= ST_IDLE;
      sc      <= '0;
      bit_idx <= '0;
      data_sr <= '0;
      par_bit <= 1'b0;
      pe_flag <= 1'b0;
    end else begin
      state   <= state_next;
      sc      <= sc_next;
      bit_idx <= bit_next;
      data_sr <= data_next;
      par_bit <= par_next;
      pe_flag <= pe_next;
    end
  end

  // The tick counter sc wraps 15->0 naturally, so each bit spans exactly 16 ticks.
  always_comb begin
    state_next = state;
    sc_next    = sc;
    bit_next   = bit_idx;
    data_next  = data_sr;
    par_next   = par_bit;
    pe_next    = pe_flag;
    push_req   = 1'b0;
    brk        = 1'b0;
    fe         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick && !rxs) begin
          state_next = ST_START;
          sc_next    = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          sc_next = sc + 4'd1;
          if (sc == 4'd7) begin
            if (rxs) begin
              state_next = ST_IDLE;
            end else begin
              state_next = ST_DATA;
              sc_next    = '0;
              bit_next   = '0;
              data_next  = '0;
              par_next   = 1'b0;
              pe_next    = 1'b0;
            end
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          sc_next = sc + 4'd1;
          if (sc == 4'd15) begin
            data_next[bit_idx] = rxs;
            if (bit_idx == last_bit_idx(char_len)) begin
              bit_next   = '0;
              state_next = parity_en ? ST_PARITY : ST_STOP1;
            end else begin
              bit_next = bit_idx + 3'd1;
            end
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          sc_next = sc + 4'd1;
          if (sc == 4'd15) begin
            par_next   = rxs;
            pe_next    = ((^data_sr) ^ rxs) != !parity_even;
            state_next = ST_STOP1;
          end
        end
      end
      ST_STOP1: begin
        if (tick) begin
          sc_next = sc + 4'd1;
          if (sc == 4'd15) begin
            fe       = !rxs;
            brk      = !rxs && (data_sr == '0) && !(parity_en && par_bit);
            push_req = 1'b1;
            if (brk) begin
              state_next = ST_BRK_WAIT;
            end else if (stop2) begin
              state_next = ST_STOP2;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
      end
      ST_STOP2: begin
        if (tick) begin
          sc_next = sc + 4'd1;
          if (sc == 4'd15) begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_BRK_WAIT: begin
        if (rxs) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    push_status           = '0;
    push_status[STAT_BRK] = brk;
    push_status[STAT_FE]  = fe | brk;
    push_status[STAT_PE]  = pe_flag;
    push_status[STAT_OE]  = ovr_pending;
    push_data             = brk ? 8'h00 : data_sr;
  end

  assign fifo_pop  = rx_valid && rx_ready;
  assign fifo_push = push_req && (!fifo_full || fifo_pop);

  // A dropped character is remembered and reported on the next one that fits.
  always_ff @(posedge wb_clock or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ovr_pending <= 1'b0;
    end else if (push_req) begin
      ovr_pending <= !fifo_push;
    end
  end

  uart_sink_fifo #(
    .WIDTH (12),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (wb_clock),
    .rst_n (wb_rst_n),
    .push  (fifo_push),
    .wdata ({push_data, push_status}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rx_data   = fifo_head[11:4];
  assign rx_status = fifo_head[3:0];
  assign rx_valid  = !fifo_empty;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_serial_sink.sv
// Scoreboard bench for uart_serial_sink: directed frames in, monitor compares popped entries.
module tb_uart_serial_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] divisor;
  logic [1:0]  char_len;
  logic        parity_en;
  logic        parity_even;
  logic        stop2;
  logic        rx;
  logic [7:0]  rx_data;
  logic [3:0]  rx_status;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  fifo_count;
  logic        busy;

  int          checks = 0;
  int          passes = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  uart_serial_sink #(
    .DIV_WIDTH  (16),
    .FIFO_DEPTH (8)
  ) dut (
    .wb_clock    (clk),
    .wb_rst_n    (rst_n),
    .divisor     (divisor),
    .char_len    (char_len),
    .parity_en   (parity_en),
    .parity_even (parity_even),
    .stop2       (stop2),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_status   (rx_status),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .fifo_count  (fifo_count),
    .busy        (busy)
  );

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every entry the DUT hands over is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_entry: got data 0x%0h status 0x%0h, expected no entry", rx_data, rx_status);
      end else begin
        logic [11:0] exp_entry;
        exp_entry = exp_q.pop_front();
        check_output("entry", {4'h0, rx_data, rx_status}, {4'h0, exp_entry});
      end
    end
  end

  function automatic logic parity_of(input logic [7:0] d, input int nbits, input logic even);
    logic p;
    p = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      p ^= d[i];
    end
    return even ? p : ~p;
  endfunction

  task automatic hold_line(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame at 16 clocks per bit; a bad stop bit is low long enough to be sampled, then released.
  task automatic apply_stimulus(input logic [7:0] d, input int nbits, input logic has_par,
                                input logic par_v, input logic stop_ok, input int nstop);
    hold_line(1'b0, 16);
    for (int i = 0; i < nbits; i++) begin
      hold_line(d[i], 16);
    end
    if (has_par) begin
      hold_line(par_v, 16);
    end
    if (stop_ok) begin
      hold_line(1'b1, 16);
    end else begin
      hold_line(1'b0, 12);
      hold_line(1'b1, 4);
    end
    if (nstop == 2) begin
      hold_line(1'b1, 16);
    end
    hold_line(1'b1, 16);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || rx_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check_output(name, 16'(exp_q.size()), 16'h0);
  endtask

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rx          = 1'b1;
    rst_n       = 1'b1;
    divisor     = 16'd1;
    char_len    = 2'b11;
    parity_en   = 1'b0;
    parity_even = 1'b0;
    stop2       = 1'b0;
    rx_ready    = 1'b1;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", {15'h0, rx_valid}, 16'h0);
    check_output("reset_data", {8'h0, rx_data}, 16'h0);
    check_output("reset_status", {12'h0, rx_status}, 16'h0);
    check_output("reset_count", {12'h0, fifo_count}, 16'h0);
    check_output("reset_busy", {15'h0, busy}, 16'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] 8N1 back-to-back characters");
    exp_q.push_back({8'hA5, 4'h0});
    apply_stimulus(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1);
    exp_q.push_back({8'h3C, 4'h0});
    apply_stimulus(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1);
    wait_drain("drain_8n1");

    $display("[TB] 7E2 with wrong parity bit");
    char_len    = 2'b10;
    parity_en   = 1'b1;
    parity_even = 1'b1;
    stop2       = 1'b1;
    exp_q.push_back({8'h41, 4'b0010});
    apply_stimulus(8'h41, 7, 1'b1, ~parity_of(8'h41, 7, 1'b1), 1'b1, 2);
    wait_drain("drain_parity");

    $display("[TB] start glitch then framing error");
    char_len  = 2'b11;
    parity_en = 1'b0;
    stop2     = 1'b0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output("glitch_busy_high", {15'h0, busy}, 16'h1);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_output("glitch_busy_low", {15'h0, busy}, 16'h0);
    check_output("glitch_no_entry", {15'h0, rx_valid}, 16'h0);
    hold_line(1'b1, 16);
    exp_q.push_back({8'h5A, 4'b0100});
    apply_stimulus(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1);
    wait_drain("drain_framing");

    $display("[TB] break of 40 bit times");
    exp_q.push_back({8'h00, 4'b1100});
    hold_line(1'b0, 640);
    check_output("break_busy", {15'h0, busy}, 16'h1);
    hold_line(1'b1, 32);
    check_output("break_released", {15'h0, busy}, 16'h0);
    exp_q.push_back({8'h11, 4'h0});
    apply_stimulus(8'h11, 8, 1'b0, 1'b0, 1'b1, 1);
    wait_drain("drain_break");

    $display("[TB] overrun with stalled consumer");
    rx_ready = 1'b0;
    for (int d = 0; d < 10; d++) begin
      if (d < 8) exp_q.push_back({8'(d), 4'h0});
      apply_stimulus(8'(d), 8, 1'b0, 1'b0, 1'b1, 1);
    end
    check_output("full_count", {12'h0, fifo_count}, 16'd8);
    check_output("full_head", {8'h0, rx_data}, 16'h00);
    rx_ready = 1'b1;
    wait_drain("drain_full");
    exp_q.push_back({8'h55, 4'b0001});
    apply_stimulus(8'h55, 8, 1'b0, 1'b0, 1'b1, 1);
    wait_drain("drain_overrun");

    $display("[TB] reset mid-frame");
    rx_ready = 1'b0;
    apply_stimulus(8'h01, 8, 1'b0, 1'b0, 1'b1, 1);
    apply_stimulus(8'h02, 8, 1'b0, 1'b0, 1'b1, 1);
    apply_stimulus(8'h03, 8, 1'b0, 1'b0, 1'b1, 1);
    check_output("queued_count", {12'h0, fifo_count}, 16'd3);
    hold_line(1'b0, 16);
    hold_line(1'b0, 16);
    hold_line(1'b0, 16);
    hold_line(1'b1, 8);
    check_output("mid_frame_busy", {15'h0, busy}, 16'h1);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check_output("rst_valid", {15'h0, rx_valid}, 16'h0);
    check_output("rst_data", {8'h0, rx_data}, 16'h0);
    check_output("rst_status", {12'h0, rx_status}, 16'h0);
    check_output("rst_count", {12'h0, fifo_count}, 16'h0);
    check_output("rst_busy", {15'h0, busy}, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx_ready = 1'b1;
    exp_q.push_back({8'h77, 4'h0});
    apply_stimulus(8'h77, 8, 1'b0, 1'b0, 1'b1, 1);
    wait_drain("drain_after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
